// File: rtl/hgcal_latent_deser.sv
// Latent-vector deserializer: gathers LANE_W-bit link words into one
// NUM_NEURONS*BW-bit vector, double-buffered against the decoder side.
module hgcal_latent_deser #(
   parameter int NUM_NEURONS = 16,
   parameter int BW          = 2,
   parameter int LANE_W      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LANE_W-1:0]         s_data,
   input  logic                      s_valid,
   input  logic                      s_sof,
   output logic                      s_ready,
   output logic [NUM_NEURONS*BW-1:0] m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      frame_err
);

   localparam int TW    = NUM_NEURONS * BW;
   localparam int WORDS = TW / LANE_W;
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LASTIX = CW'(WORDS - 1);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt, widx;
   logic [TW-1:0]   asm_q, asm_nxt, md_q;
   logic            mv_q, err_q, err_d;
   logic            last, xfer, store, done;

   // next state, word slot, ready and error decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      widx      = '0;
      last      = 1'b0;
      store     = 1'b0;
      err_d     = 1'b0;
      unique case (state)
         IDLE:    last = s_sof && (WORDS == 1);
         COLLECT: begin
            last = !s_sof && (cnt == LASTIX);
            widx = s_sof ? '0 : cnt;
         end
         default: last = 1'b0;
      endcase
      // only a frame-completing word needs room in the output register
      s_ready = !rst && !(last && mv_q && !m_ready);
      xfer    = s_valid && s_ready;
      if (xfer) begin
         unique case (state)
            IDLE: begin
               if (s_sof) begin
                  store = 1'b1;
                  if (WORDS > 1) begin
                     state_nxt = COLLECT;
                     cnt_nxt   = CW'(1);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            COLLECT: begin
               store = 1'b1;
               if (s_sof) begin
                  cnt_nxt = CW'(1);
                  err_d   = 1'b1;
               end else if (cnt == LASTIX) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      done    = xfer && last;
      asm_nxt = asm_q;
      for (int k = 0; k < WORDS; k++) begin
         if (widx == CW'(k)) asm_nxt[k*LANE_W +: LANE_W] = s_data;
      end
   end

   // state and word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // assembly buffer, output register and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q <= '0;
         md_q  <= '0;
         mv_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
         if (store) asm_q <= asm_nxt;
         if (done) begin
            md_q <= asm_nxt;
            mv_q <= 1'b1;
         end else if (m_ready) begin
            mv_q <= 1'b0;
         end
      end
   end

   assign m_data    = md_q;
   assign m_valid   = mv_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_hgcal_latent_deser.sv
// Bench for hgcal_latent_deser: default 4-word build plus a 1-word build,
// each with a scoreboard of expected vectors.
module tb_hgcal_latent_deser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_sof = 1'b0, s_ready;
   logic [31:0] m_data;
   logic        m_valid, m_ready = 1'b1, frame_err;
   logic        lastw = 1'b0;

   logic [7:0]  s_data1 = '0;
   logic        s_valid1 = 1'b0, s_sof1 = 1'b0, s_ready1;
   logic [7:0]  m_data1;
   logic        m_valid1, frame_err1;
   logic        lastw1 = 1'b0;

   int          n_chk = 0, n_fail = 0, errs = 0, outs1 = 0, e0;
   logic [31:0] q[$];
   logic [7:0]  q1[$];
   logic        lhs = 0, pv = 0, pr = 0;
   logic        lhs1 = 0, pv1 = 0;

   hgcal_latent_deser dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .frame_err(frame_err)
   );

   hgcal_latent_deser #(.NUM_NEURONS(4), .BW(2), .LANE_W(8)) dut1 (
      .clk(clk), .rst(rst),
      .s_data(s_data1), .s_valid(s_valid1), .s_sof(s_sof1),
      .s_ready(s_ready1),
      .m_data(m_data1), .m_valid(m_valid1), .m_ready(1'b1),
      .frame_err(frame_err1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // scoreboard for the default build
   always @(negedge clk) begin
      if (rst) begin
         lhs = 0; pv = 0; pr = 0;
      end else begin
         if (lhs) chk("lat", m_valid, 1);
         if (m_valid && (!pv || pr)) begin
            if (q.size() == 0) chk("unexp", m_valid, 0);
            else chk("data", m_data, q.pop_front());
         end
         if (frame_err) errs++;
         lhs = s_valid && s_ready && lastw;
         pv  = m_valid;
         pr  = m_ready;
      end
   end

   // scoreboard for the one-word build
   always @(negedge clk) begin
      if (rst) begin
         lhs1 = 0; pv1 = 0;
      end else begin
         if (lhs1) chk("lat1", m_valid1, 1);
         if (m_valid1 && (!pv1 || 1'b1)) begin
            outs1++;
            if (q1.size() == 0) chk("unexp1", m_valid1, 0);
            else chk("data1", m_data1, q1.pop_front());
         end
         if (frame_err1) chk("err1", frame_err1, 0);
         lhs1 = s_valid1 && s_ready1 && lastw1;
         pv1  = m_valid1;
      end
   end

   task automatic send(input logic [7:0] d, input logic sof,
                       input logic lw, input logic [31:0] exp);
      int n;
      s_data = d; s_valid = 1; s_sof = sof; lastw = lw;
      if (lw) q.push_back(exp);
      @(negedge clk);
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("rdy_to", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 0; s_sof = 0; lastw = 0;
   endtask

   task automatic frame(input logic [31:0] v);
      send(v[7:0],   1, 0, v);
      send(v[15:8],  0, 0, v);
      send(v[23:16], 0, 0, v);
      send(v[31:24], 0, 1, v);
   endtask

   task automatic send1(input logic [7:0] d);
      s_data1 = d; s_valid1 = 1; s_sof1 = 1; lastw1 = 1;
      q1.push_back(d);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mv", m_valid, 0);
      chk("rst_md", m_data, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_rdy", s_ready, 0);
      chk("rst_mv1", m_valid1, 0);
      @(posedge clk); #1 rst = 0;

      // nominal frame
      frame(32'hFF001BE4);
      @(negedge clk);
      chk("nom_md", m_data, 32'hFF001BE4);
      chk("n0", m_data[1:0], 2'b00);
      chk("n1", m_data[3:2], 2'b01);
      chk("n15", m_data[31:30], 2'b11);
      @(negedge clk);
      chk("acc_mv", m_valid, 0);
      chk("acc_md", m_data, 32'hFF001BE4);
      idle(1);

      // back-pressure
      m_ready = 0;
      frame(32'h44332211);
      send(8'hA1, 1, 0, 0);
      send(8'hB2, 0, 0, 0);
      send(8'hC3, 0, 0, 0);
      s_data = 8'hD4; s_valid = 1; s_sof = 0; lastw = 1;
      q.push_back(32'hD4C3B2A1);
      @(negedge clk);
      chk("bp_rdy", s_ready, 0);
      chk("bp_mv", m_valid, 1);
      chk("bp_hold", m_data, 32'h44332211);
      @(posedge clk); #1 m_ready = 1;
      @(negedge clk);
      chk("bp_rdy2", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 0; lastw = 0;
      idle(3);

      // missing sof
      e0 = errs;
      send(8'h55, 0, 0, 0);
      @(negedge clk);
      chk("miss_pulse", frame_err, 1);
      @(negedge clk);
      chk("miss_1cyc", frame_err, 0);
      @(posedge clk); #1;
      frame(32'h87654321);
      idle(3);
      chk("miss_err", errs - e0, 1);

      // early sof
      e0 = errs;
      send(8'h9A, 1, 0, 0);
      send(8'h9B, 0, 0, 0);
      send(8'h11, 1, 0, 0);
      send(8'h22, 0, 0, 0);
      send(8'h33, 0, 0, 0);
      send(8'h44, 0, 1, 32'h44332211);
      idle(3);
      chk("early_err", errs - e0, 1);

      // reset mid-frame
      send(8'h77, 1, 0, 0);
      send(8'h78, 0, 0, 0);
      rst = 1;
      @(negedge clk);
      chk("mrst_rdy", s_ready, 0);
      @(posedge clk); #1 rst = 0;
      e0 = errs;
      @(negedge clk);
      chk("mrst_mv", m_valid, 0);
      chk("mrst_err", frame_err, 0);
      @(posedge clk); #1;
      frame(32'hCAFE0B0E);
      idle(3);
      chk("mrst_errs", errs - e0, 0);
      chk("q_empty", q.size(), 0);

      // one-word build, back-to-back
      send1(8'h1E);
      send1(8'h2D);
      send1(8'h3C);
      s_valid1 = 0; lastw1 = 0;
      idle(3);
      chk("w1_outs", outs1, 3);
      chk("q1_empty", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
